// File: rtl/ram_stream_reader.sv
// Streams a contiguous RAM address range out as a valid/ready stream with a last-beat marker.
// Read issue is credit-limited so that in-flight reads plus buffered words never exceed the FIFO.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int LEN_WIDTH  = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_en,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [LEN_WIDTH-1:0] DEPTH_L = LEN_WIDTH'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state, state_d;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issue_cnt;
  logic [LEN_WIDTH-1:0]  pop_cnt;
  logic [LEN_WIDTH-1:0]  in_flight;
  logic                  ram_last;
  logic                  cap_vld;
  logic                  cap_last;
  logic [PTR_W:0]        wr_ptr, rd_ptr;
  logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
  logic [DATA_WIDTH:0]   head;
  logic                  pop;
  logic                  credit;
  logic                  issue;
  logic                  issue_last;
  logic                  done_d;

  assign head     = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign m_tvalid = (wr_ptr != rd_ptr);
  assign m_tdata  = head[DATA_WIDTH-1:0];
  assign m_tlast  = m_tvalid & head[DATA_WIDTH];
  assign busy     = (state != IDLE);
  assign pop      = m_tvalid & m_tready;

  // Outstanding words = issued reads not yet popped, counting a pop happening this cycle.
  assign in_flight = issue_cnt - pop_cnt - LEN_WIDTH'(pop);
  assign credit    = (in_flight < DEPTH_L);

  always_comb begin
    state_d    = state;
    issue      = 1'b0;
    issue_last = 1'b0;
    done_d     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            issue      = 1'b1;
            issue_last = (length == LEN_WIDTH'(1));
            state_d    = issue_last ? DRAIN : READ;
          end
        end
      end
      READ: begin
        if (credit) begin
          issue      = 1'b1;
          issue_last = (issue_cnt + LEN_WIDTH'(1) == len_q);
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_tlast) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      done      <= 1'b0;
      ram_en    <= 1'b0;
      ram_addr  <= '0;
      ram_last  <= 1'b0;
      len_q     <= '0;
      issue_cnt <= '0;
      pop_cnt   <= '0;
      cap_vld   <= 1'b0;
      cap_last  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      done     <= done_d;
      ram_en   <= issue;
      ram_last <= issue_last;
      cap_vld  <= ram_en;
      cap_last <= ram_last;
      if (state == IDLE) begin
        if (start) len_q <= length;
        issue_cnt <= LEN_WIDTH'(issue);
        pop_cnt   <= '0;
        if (issue) ram_addr <= base_addr;
      end else begin
        if (issue) begin
          issue_cnt <= issue_cnt + LEN_WIDTH'(1);
          ram_addr  <= ram_addr + ADDR_WIDTH'(1);
        end
        if (pop) pop_cnt <= pop_cnt + LEN_WIDTH'(1);
      end
      if (cap_vld) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: occupancy is tracked entirely by the pointers.
  always_ff @(posedge CLK) begin
    if (cap_vld) fifo_mem[wr_ptr[PTR_W-1:0]] <= {cap_last, ram_dout};
  end

endmodule
